// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller slice.
// Contents: data/register-file geometry, ALU op-code constants,
// the controller FSM state encoding and the legal-op check.
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int IDX_W    = 2;
    localparam int RF_DEPTH = 4;
    localparam int OP_W     = 4;

    // ALU op codes as carried on alu_ctr
    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b1000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b1001;
    localparam logic [OP_W-1:0] OP_XOR = 4'b1010;
    localparam logic [OP_W-1:0] OP_NOT = 4'b1011;
    localparam logic [OP_W-1:0] OP_SHR = 4'b1100;
    localparam logic [OP_W-1:0] OP_SHL = 4'b1101;
    localparam logic [OP_W-1:0] OP_ROR = 4'b1110;
    localparam logic [OP_W-1:0] OP_ROL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_CAPT  = 2'd3
    } state_e;

    // Codes 0010..0111 are unassigned and must be rejected.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHR, OP_SHL, OP_ROR, OP_ROL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Bus bundle between the instruction source / ALU stage (master side)
// and the alu_ctrl controller (slave side).
//   in_*      : instruction offer with valid/ready handshake
//   alu_a/b   : operand drive to the ALU stage, alu_ctr its op code
//   alu_o     : ALU stage result
//   out_*     : write-back report, err : illegal-op pulse
interface alu_ctrl_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [IDX_W-1:0]  in_sa;
    logic [IDX_W-1:0]  in_sb;
    logic [IDX_W-1:0]  in_dst;
    logic              in_imm_en;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctr;
    logic [DATA_W-1:0] alu_o;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_dst;
    logic              err;

    modport master (
        output in_valid, in_op, in_sa, in_sb, in_dst, in_imm_en, in_imm, alu_o,
        input  in_ready, alu_a, alu_b, alu_ctr, out_valid, out_data, out_dst, err
    );

    modport slave (
        input  in_valid, in_op, in_sa, in_sb, in_dst, in_imm_en, in_imm, alu_o,
        output in_ready, alu_a, alu_b, alu_ctr, out_valid, out_data, out_dst, err
    );

endinterface

// File: rtl/alu_rf.sv
// 4 x 8-bit register file for the ALU controller.
// Ports: ck/rst_n (async active-low clear of every entry),
//        rd_a_idx/rd_a_data and rd_b_idx/rd_b_data (combinational reads),
//        wr_en/wr_idx/wr_data (write on rising edge of ck).
module alu_rf
    import alu_pkg::*;
(
    input  logic              ck,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_a_idx,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [IDX_W-1:0]  rd_b_idx,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem_r [RF_DEPTH];

    // Storage: cleared on reset, single write port
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Reads are combinational so a value written at one edge is visible
    // to an instruction accepted at the very next edge.
    assign rd_a_data = mem_r[rd_a_idx];
    assign rd_b_data = mem_r[rd_b_idx];

endmodule

// File: rtl/alu_ctrl.sv
// ALU controller: accepts one instruction at a time, drives operands and
// op code to an external two-register ALU stage, captures its result and
// writes it back to the register file.
// Ports: ck, rst_n (async active-low), bus (alu_ctrl_if.slave) carrying
//        the instruction handshake, ALU drive/result, write-back report
//        and the illegal-op error pulse.
// Timing for a legal op accepted at edge T:
//   T+1 ISSUE (alu_* valid), T+2 EXEC, T+3 CAPT, alu_o sampled at the edge
//   ending CAPT, out_valid high for the following cycle (back in IDLE).
module alu_ctrl
    import alu_pkg::*;
(
    input  logic       ck,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus
);

    state_e            state_r;
    state_e            state_s;

    logic              in_ready_r;
    logic              hs_s;
    logic              legal_s;
    logic              accept_s;
    logic              wr_en_s;

    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [OP_W-1:0]   alu_ctr_r;
    logic [IDX_W-1:0]  dst_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [IDX_W-1:0]  out_dst_r;
    logic              err_r;

    assign hs_s     = bus.in_valid & in_ready_r;
    assign legal_s  = is_legal_op(bus.in_op);
    assign accept_s = hs_s & legal_s;
    // The ALU result has passed both stage registers only by the end of CAPT.
    assign wr_en_s  = (state_r == ST_CAPT);

    alu_rf u_rf (
        .ck        (ck),
        .rst_n     (rst_n),
        .rd_a_idx  (bus.in_sa),
        .rd_a_data (rd_a_s),
        .rd_b_idx  (bus.in_sb),
        .rd_b_data (rd_b_s),
        .wr_en     (wr_en_s),
        .wr_idx    (dst_r),
        .wr_data   (bus.alu_o)
    );

    // FSM state register
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; illegal ops are consumed without leaving IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_EXEC;
            ST_EXEC:  state_s = ST_CAPT;
            ST_CAPT:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Registered ready: high exactly while the FSM sits in IDLE
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= (state_s == ST_IDLE);
        end
    end

    // Operand/op-code launch; held until the next accepted legal op
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r   <= 8'h00;
            alu_b_r   <= 8'h00;
            alu_ctr_r <= 4'b0000;
            dst_r     <= 2'd0;
        end else if (accept_s) begin
            alu_a_r   <= rd_a_s;
            alu_b_r   <= bus.in_imm_en ? bus.in_imm : rd_b_s;
            alu_ctr_r <= bus.in_op;
            dst_r     <= bus.in_dst;
        end
    end

    // Write-back report and illegal-op pulse
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_dst_r   <= 2'd0;
            err_r       <= 1'b0;
        end else begin
            out_valid_r <= wr_en_s;
            err_r       <= hs_s & ~legal_s;
            if (wr_en_s) begin
                out_data_r <= bus.alu_o;
                out_dst_r  <= dst_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_ctr   = alu_ctr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_dst   = out_dst_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl with a two-register ALU stage model.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic ck;
    logic rst_n;
    int   total;
    int   bad;
    int   edge_cnt;

    typedef struct {
        logic [7:0] data;
        logic [1:0] dst;
        int         t;
    } exp_t;

    exp_t sb_q[$];
    int   err_q[$];

    alu_ctrl_if bus();

    alu_ctrl dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    always @(posedge ck) edge_cnt <= edge_cnt + 1;

    // ALU stage: two register stages between alu_a/b/ctr and alu_o
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c);
        logic [7:0] r;
        case (c)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b1000: r = a & b;
            4'b1001: r = a | b;
            4'b1010: r = a ^ b;
            4'b1011: r = ~a;
            4'b1100: r = {1'b0, a[7:1]};
            4'b1101: r = {a[6:0], 1'b0};
            4'b1110: r = {a[0], a[7:1]};
            4'b1111: r = {a[6:0], a[7]};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [7:0] stg1;
    logic [7:0] stg2;

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            stg1 <= 8'h00;
            stg2 <= 8'h00;
        end else begin
            stg1 <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctr);
            stg2 <= stg1;
        end
    end
    assign bus.alu_o = stg2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected write-backs / error pulses as the DUT reports them
    always @(negedge ck) begin
        exp_t e;
        int   et;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
                chk("out_dst", {30'd0, bus.out_dst}, {30'd0, e.dst});
                chk("out_timing", edge_cnt, e.t + 3);
            end
        end
        if (rst_n === 1'b1 && bus.err === 1'b1) begin
            if (err_q.size() == 0) begin
                chk("spurious_err", 32'd1, 32'd0);
            end else begin
                et = err_q.pop_front();
                chk("err_timing", edge_cnt, et);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_a"}, {24'd0, bus.alu_a}, 32'h0);
        chk({tag, "_alu_b"}, {24'd0, bus.alu_b}, 32'h0);
        chk({tag, "_alu_ctr"}, {28'd0, bus.alu_ctr}, 32'h0);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'h0);
        chk({tag, "_out_data"}, {24'd0, bus.out_data}, 32'h0);
        chk({tag, "_out_dst"}, {30'd0, bus.out_dst}, 32'h0);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'h0);
    endtask

    // Offer one instruction (called at a negedge); returns the handshake edge
    task automatic issue(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] dst, input logic imm_en, input logic [7:0] imm,
                         input logic push, input logic [7:0] exp_data, output int t);
        int   n;
        logic legal;
        exp_t e;
        legal         = is_legal_op(op);
        bus.in_op     = op;
        bus.in_sa     = sa;
        bus.in_sb     = sb;
        bus.in_dst    = dst;
        bus.in_imm_en = imm_en;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge ck);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            t = -1;
        end else begin
            t = edge_cnt + 1;
            if (!legal) begin
                err_q.push_back(t);
            end else if (push) begin
                e.data = exp_data;
                e.dst  = dst;
                e.t    = t;
                sb_q.push_back(e);
            end
            @(posedge ck);
            @(negedge ck);
            chk("ready_after_hs", {31'd0, bus.in_ready}, legal ? 32'd0 : 32'd1);
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        int t1;
        int t2;
        total = 0;
        bad = 0;
        edge_cnt = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 4'd0;
        bus.in_sa = 2'd0;
        bus.in_sb = 2'd0;
        bus.in_dst = 2'd0;
        bus.in_imm_en = 1'b0;
        bus.in_imm = 8'h00;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
        @(negedge ck);

        // add r0 + 0x05 -> r1
        issue(4'b0000, 2'd0, 2'd0, 2'd1, 1'b1, 8'h05, 1'b1, 8'h05, t1);
        // sub r1 - 0x07 -> r2, wraps
        issue(4'b0001, 2'd1, 2'd0, 2'd2, 1'b1, 8'h07, 1'b1, 8'hFE, t1);
        // load r3 = 0x81
        issue(4'b0000, 2'd0, 2'd0, 2'd3, 1'b1, 8'h81, 1'b1, 8'h81, t1);
        // ror r3 -> r2 ; rol r3 -> r2
        issue(4'b1110, 2'd3, 2'd0, 2'd2, 1'b0, 8'h00, 1'b1, 8'hC0, t1);
        issue(4'b1111, 2'd3, 2'd0, 2'd2, 1'b0, 8'h00, 1'b1, 8'h03, t1);
        // xor r3 ^ r2 (register B path) -> r2
        issue(4'b1010, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 1'b1, 8'h82, t1);

        // illegal op targeting r1: error pulse only
        issue(4'b0010, 2'd0, 2'd0, 2'd1, 1'b1, 8'hAA, 1'b1, 8'h00, t1);
        chk("illegal_alu_ctr_held", {28'd0, bus.alu_ctr}, 32'hA);
        chk("illegal_alu_a_held", {24'd0, bus.alu_a}, 32'h81);
        chk("illegal_alu_b_held", {24'd0, bus.alu_b}, 32'h03);
        // r1 must still hold 0x05
        issue(4'b0000, 2'd1, 2'd0, 2'd1, 1'b1, 8'h00, 1'b1, 8'h05, t1);

        // back-to-back read-after-write on r1
        issue(4'b0000, 2'd0, 2'd0, 2'd1, 1'b1, 8'h10, 1'b1, 8'h10, t1);
        issue(4'b0000, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1'b1, 8'h20, t2);
        chk("raw_hs_spacing", t2, t1 + 4);

        // not / shr / and-immediate
        issue(4'b1011, 2'd1, 2'd0, 2'd3, 1'b0, 8'h00, 1'b1, 8'hDF, t1);
        issue(4'b1100, 2'd3, 2'd0, 2'd3, 1'b0, 8'h00, 1'b1, 8'h6F, t1);
        issue(4'b1000, 2'd3, 2'd0, 2'd0, 1'b1, 8'h0F, 1'b1, 8'h0F, t1);

        // reset during EXEC: instruction discarded
        issue(4'b0000, 2'd1, 2'd0, 2'd2, 1'b1, 8'h01, 1'b0, 8'h00, t1);
        @(negedge ck);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        #1;
        chk("ready_after_mid_reset", {31'd0, bus.in_ready}, 32'd1);
        repeat (5) @(negedge ck);
        // register file cleared
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 1'b1, 8'h00, t1);
        issue(4'b1001, 2'd3, 2'd2, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, t1);

        repeat (8) @(negedge ck);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("err_queue_drained", err_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port ck  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  instruction offered.
REQ-004 SHALL have port in_ready  output  1  controller accepts instruction this cycle.
REQ-005 SHALL have port in_op  input  4  ALU op code (0000 add, 0001 sub, 1000 and, 1001 or, 1010 xor, 1011 not A, 1100 shr, 1101 shl, 1110 ror, 1111 rol).
REQ-006 SHALL have ports in_sa, in_sb, in_dst  input  2 each  source A, source B, destination register index.
REQ-007 SHALL have ports in_imm_en  input  1 and in_imm  input  8  replace source B with immediate.
REQ-008 SHALL have ports alu_a, alu_b  output  8 and alu_ctr  output  4  registered drive to the ALU stage A/B/CTR.
REQ-009 SHALL have port alu_o  input  8  ALU stage result O.
REQ-010 SHALL have ports out_valid  output  1, out_data  output  8, out_dst  output  2  write-back report.
REQ-011 SHALL have port err  output  1  one-cycle illegal-op pulse.

Function
REQ-012 SHALL contain a 4 x 8-bit register file; entry written only in CAPT state.
REQ-013 SHALL implement FSM states IDLE, ISSUE, EXEC, CAPT; IDLE->ISSUE on accepted legal op, ISSUE->EXEC->CAPT->IDLE unconditionally.
REQ-014 SHALL assert in_ready only in IDLE; handshake = in_valid & in_ready at rising edge.
REQ-015 SHALL, on handshake at edge T, load alu_a=rf[in_sa], alu_b=in_imm_en ? in_imm : rf[in_sb], alu_ctr=in_op, latch in_dst; values valid from cycle T+1 (ISSUE).
REQ-016 SHALL hold alu_a/alu_b/alu_ctr stable until the next handshake.
REQ-017 SHALL, at the edge ending CAPT (T+3), write alu_o into rf[dst] and register out_data=alu_o, out_dst=dst, out_valid=1 for exactly cycle T+4.
REQ-018 SHALL account for the ALU stage's two-register latency: alu_o sampled only at end of CAPT, never earlier.
REQ-019 SHALL treat op codes 0010-0111 as illegal: accept the handshake, pulse err for one cycle after it, remain in IDLE, leave rf/alu_* unchanged, no out_valid.
REQ-020 SHALL give throughput of one legal instruction per 4 cycles; handshake permitted in the same cycle out_valid is high.
REQ-021 SHALL read rf at handshake, so an instruction accepted at T+4 sees the value written at T+3 (no hazard).
REQ-022 SHALL keep arithmetic 8-bit modulo 256; no carry/flag output.

Reset
REQ-023 SHALL, on rst_n low (any state, asynchronous), force state IDLE, rf all 0x00, alu_a/alu_b=0x00, alu_ctr=0000, out_valid=0, out_data=0x00, out_dst=0, err=0; in_ready=1 after release.
REQ-024 SHALL discard an in-flight instruction when reset is asserted mid-operation; no out_valid afterward.

Structure
REQ-025 SHALL place op-code constants, legal-op check function and FSM state encoding in shared package alu_pkg.
REQ-026 SHALL implement the register file as sub-module alu_rf (2 async read ports, 1 sync write port, async active-low clear).

Verification (bench instantiates alu_ctrl driving a real ALU stage)
REQ-027 SHALL check: after reset, add r0+imm 0x05 dst=1 handshake at T -> out_valid at T+4, out_data=0x05, out_dst=1.
REQ-028 SHALL check: sub r1(0x05) - imm 0x07 dst=2 -> out_data=0xFE (wrap).
REQ-029 SHALL check: ror on r3=0x81 (loaded via add imm) -> 0xC0; rol on 0x81 -> 0x03.
REQ-030 SHALL check: back-to-back RAW, add imm 0x10 dst=1 then add r1+r1 dst=1 offered continuously -> second handshake exactly at first's T+4, result 0x20.
REQ-031 SHALL check: op 0010 offered -> err=1 one cycle, in_ready stays 1, no out_valid, rf unchanged.
REQ-032 SHALL check: rst_n low during EXEC -> outputs at reset values immediately, no out_valid, rf reads 0x00 afterward.
